spi_flash_phy: RTL and testbench

Parametrised bit-level serial flash PHY. It replaces the single-lane byte shifter and adds dual and quad I/O, a programmable SCK divider and a programmable chip-select deselect gap. A byte-wide command layer above it issues one byte per request. The block drives the flash pins directly: SPI mode 0, MSB first, one byte per transaction.

---
 rtl/spi_flash_phy_if.sv | 35 +++
 rtl/spi_flash_phy.sv | 271 +++++++++++++++++++++++++++
 tb/tb_spi_flash_phy.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_phy_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_phy_if
// Description : Byte-request bus between the command layer and the serial
//               flash PHY.
//               master : command layer (drives requests, sees status)
//               slave  : PHY (accepts requests, returns data/status)
//   write/read  request strobes (write wins when both high)
//   deselect    raise chip select after this byte
//   mode        lane mode: 00 single, 01 dual, 10 quad, 11 single
//   din/dout    byte to send / last byte received
//   done/busy   completion pulse / transfer in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_flash_phy_if;
    logic       write;
    logic       read;
    logic       deselect;
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] dout;
    logic       done;
    logic       busy;

    modport master (
        output write, read, deselect, mode, din,
        input  dout, done, busy
    );

    modport slave (
        input  write, read, deselect, mode, din,
        output dout, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_phy.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_phy
// Description : Bit-level serial flash PHY. SPI mode 0, MSB first, one byte
//               per request, single/dual/quad lanes, programmable SCK divider
//               and chip-select deselect gap.
//   clk, reset_n     system clock, asynchronous active-low reset
//   bus (slave)      byte request/status bus
//   flash_c          SCK
//   flash_s_n        chip select, active low
//   flash_dq_o/_oe   lane outputs and per-lane output enables
//   flash_dq_i       lane inputs
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_phy #(
    parameter int CLK_DIV         = 1,
    parameter int DESELECT_CYCLES = 10,
    parameter int CNT_W           = 8
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    spi_flash_phy_if.slave   bus,
    output logic             flash_c,
    output logic             flash_s_n,
    output logic [3:0]       flash_dq_o,
    output logic [3:0]       flash_dq_oe,
    input  wire logic [3:0]  flash_dq_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2,
        ST_DESEL = 2'd3
    } state_t;

    // Internal lane code: 0 single, 1 dual, 2 quad
    localparam logic [1:0]       LANE_1 = 2'd0;
    localparam logic [1:0]       LANE_2 = 2'd1;
    localparam logic [1:0]       LANE_4 = 2'd2;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    // Only meaningful when DESELECT_CYCLES >= 2; the first deselect cycle is
    // the one right after the last SCK half-period.
    localparam logic [CNT_W-1:0] DESEL_LAST = CNT_W'(DESELECT_CYCLES - 2);
    localparam logic [3:0]       DQ_IDLE = 4'b1100;
    localparam logic [3:0]       OE_IDLE = 4'b1101;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       grp_q, grp_d;
    logic [1:0]       lane_q, lane_d;
    logic             wr_q, wr_d;
    logic             desel_q, desel_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       dout_q, dout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             sck_q, sck_d;
    logic             csn_q, csn_d;
    logic [3:0]       dq_o_q, dq_o_d;
    logic [3:0]       dq_oe_q, dq_oe_d;

    logic [1:0]       lane_new;
    logic [7:0]       sh_wr_next;
    logic [7:0]       drive;

    // Lane pattern {dq_o, dq_oe} for one group. In non-quad modes dq3/dq2
    // (HOLD#/WP#) stay driven high.
    function automatic logic [7:0] lane_drive(input logic       wr,
                                              input logic [1:0] lane,
                                              input logic [7:0] sh);
        logic [7:0] r;
        r = {DQ_IDLE, OE_IDLE};
        if (wr) begin
            case (lane)
                LANE_2:  r = {2'b11, sh[7:6], 4'b1111};
                LANE_4:  r = {sh[7:4], 4'b1111};
                default: r = {3'b110, sh[7], 4'b1101};
            endcase
        end else begin
            case (lane)
                LANE_2:  r = {4'b1100, 4'b1100};
                LANE_4:  r = {4'b0000, 4'b0000};
                default: r = {4'b1100, 4'b1101};
            endcase
        end
        return r;
    endfunction

    // Received bits enter from the LSB side; single mode listens on dq1 (MISO).
    function automatic logic [7:0] shift_in(input logic [1:0] lane,
                                            input logic [7:0] sh,
                                            input logic [3:0] dq);
        logic [7:0] r;
        case (lane)
            LANE_2:  r = {sh[5:0], dq[1:0]};
            LANE_4:  r = {sh[3:0], dq};
            default: r = {sh[6:0], dq[1]};
        endcase
        return r;
    endfunction

    function automatic logic [2:0] last_group(input logic [1:0] lane);
        logic [2:0] r;
        case (lane)
            LANE_2:  r = 3'd3;
            LANE_4:  r = 3'd1;
            default: r = 3'd7;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grp_d      = grp_q;
        lane_d     = lane_q;
        wr_d       = wr_q;
        desel_d    = desel_q;
        sh_d       = sh_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        sck_d      = sck_q;
        csn_d      = csn_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = dq_oe_q;
        lane_new   = LANE_1;
        sh_wr_next = sh_q;
        drive      = {DQ_IDLE, OE_IDLE};

        case (bus.mode)
            2'b01:   lane_new = LANE_2;
            2'b10:   lane_new = LANE_4;
            default: lane_new = LANE_1;
        endcase

        case (lane_q)
            LANE_2:  sh_wr_next = {sh_q[5:0], 2'b00};
            LANE_4:  sh_wr_next = {sh_q[3:0], 4'b0000};
            default: sh_wr_next = {sh_q[6:0], 1'b0};
        endcase

        case (state_q)
            ST_IDLE: begin
                if (busy_q) begin
                    // done cycle: busy is still high, nothing is accepted yet
                    busy_d = 1'b0;
                end else if (bus.write || bus.read) begin
                    wr_d    = bus.write;
                    lane_d  = lane_new;
                    desel_d = bus.deselect;
                    sh_d    = bus.din;
                    busy_d  = 1'b1;
                    csn_d   = 1'b0;
                    cnt_d   = '0;
                    grp_d   = 3'd0;
                    drive   = lane_drive(bus.write, lane_new, bus.din);
                    {dq_o_d, dq_oe_d} = drive;
                    state_d = ST_LO;
                end
            end

            ST_LO: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    // the rising SCK edge is where the flash data is captured
                    if (!wr_q) begin
                        sh_d = shift_in(lane_q, sh_q, flash_dq_i);
                    end
                    state_d = ST_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HI: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (grp_q == last_group(lane_q)) begin
                        dq_o_d  = DQ_IDLE;
                        dq_oe_d = OE_IDLE;
                        if (!wr_q) begin
                            dout_d = sh_q;
                        end
                        if (desel_q) begin
                            csn_d = 1'b1;
                            if (DESELECT_CYCLES == 1) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_DESEL;
                            end
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        grp_d = grp_q + 3'd1;
                        if (wr_q) begin
                            sh_d = sh_wr_next;
                        end
                        drive = lane_drive(wr_q, lane_q, sh_wr_next);
                        {dq_o_d, dq_oe_d} = drive;
                        state_d = ST_LO;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DESEL: begin
                if (cnt_q == DESEL_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grp_q   <= 3'd0;
            lane_q  <= LANE_1;
            wr_q    <= 1'b0;
            desel_q <= 1'b0;
            sh_q    <= 8'h00;
            dout_q  <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sck_q   <= 1'b0;
            csn_q   <= 1'b1;
            dq_o_q  <= DQ_IDLE;
            dq_oe_q <= OE_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            lane_q  <= lane_d;
            wr_q    <= wr_d;
            desel_q <= desel_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            sck_q   <= sck_d;
            csn_q   <= csn_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign flash_c     = sck_q;
    assign flash_s_n   = csn_q;
    assign flash_dq_o  = dq_o_q;
    assign flash_dq_oe = dq_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_phy.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_phy
// Description : Self-checking bench for spi_flash_phy. Three instances with
//               CLK_DIV = 1, 2, 3 share clock and reset; each byte is checked
//               cycle by cycle against waveform timing derived from D, the
//               lane count and the deselect flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_phy;

    localparam int DESEL = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       wr_a [3];
    logic       rd_a [3];
    logic       ds_a [3];
    logic [1:0] md_a [3];
    logic [7:0] din_a [3];
    logic [3:0] dqi_a [3];
    logic [7:0] dout_a [3];
    logic       done_a [3];
    logic       busy_a [3];
    logic       c_a [3];
    logic       sn_a [3];
    logic [3:0] dqo_a [3];
    logic [3:0] oe_a [3];

    logic [7:0] dout_m [3];
    logic       csn_m [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            spi_flash_phy_if bus ();
            assign bus.write    = wr_a[g];
            assign bus.read     = rd_a[g];
            assign bus.deselect = ds_a[g];
            assign bus.mode     = md_a[g];
            assign bus.din      = din_a[g];
            assign dout_a[g]    = bus.dout;
            assign done_a[g]    = bus.done;
            assign busy_a[g]    = bus.busy;

            spi_flash_phy #(
                .CLK_DIV         (g + 1),
                .DESELECT_CYCLES (DESEL),
                .CNT_W           (8)
            ) u_dut (
                .clk         (clk),
                .reset_n     (reset_n),
                .bus         (bus),
                .flash_c     (c_a[g]),
                .flash_s_n   (sn_a[g]),
                .flash_dq_o  (dqo_a[g]),
                .flash_dq_oe (oe_a[g]),
                .flash_dq_i  (dqi_a[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic chk_idle_pins(input string tag, input int i);
        chk({tag, "_c"},    i, 8'(c_a[i]),    8'h00);
        chk({tag, "_sn"},   i, 8'(sn_a[i]),   8'h01);
        chk({tag, "_dq"},   i, 8'(dqo_a[i]),  8'h0C);
        chk({tag, "_oe"},   i, 8'(oe_a[i]),   8'h0D);
        chk({tag, "_busy"}, i, 8'(busy_a[i]), 8'h00);
        chk({tag, "_done"}, i, 8'(done_a[i]), 8'h00);
        chk({tag, "_dout"}, i, dout_a[i],     8'h00);
    endtask

    // One byte on instance i. Called at #1 after a rising edge (cycle T);
    // returns at #1 after the edge that ends the done cycle, so an immediate
    // second call is a back-to-back request.
    task automatic do_byte(input int i, input bit w, input bit r, input logic [1:0] m,
                           input logic [7:0] d, input bit ds, input logic [7:0] rb,
                           input bit poke);
        int D, L, N, endj, donej, k;
        bit is_wr, exp_c;
        logic [7:0] tmp, mask, exp_oe, exp_bits, obs_bits;
        logic [3:0] q;

        D     = i + 1;
        L     = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
        N     = 8 / L;
        is_wr = w;
        endj  = 2 * N * D;
        donej = ds ? endj + DESEL : endj + 1;
        mask  = 8'((1 << L) - 1);
        if (is_wr) exp_oe = (L == 1) ? 8'h0D : 8'h0F;
        else       exp_oe = (L == 1) ? 8'h0D : (L == 2) ? 8'h0C : 8'h00;

        chk("start_busy", i, 8'(busy_a[i]), 8'h00);
        chk("start_sn",   i, 8'(sn_a[i]),   8'(csn_m[i]));

        wr_a[i] = w; rd_a[i] = r; md_a[i] = m; din_a[i] = d; ds_a[i] = ds;
        @(posedge clk); #1;
        din_a[i] = 8'($urandom); md_a[i] = 2'($urandom); ds_a[i] = 1'($urandom);

        for (int j = 1; j <= donej; j++) begin
            wr_a[i] = poke && (j == 3);
            rd_a[i] = poke && (j == 3);
            if (j <= endj) begin
                k   = (j - 1) / (2 * D);
                tmp = rb >> (8 - L * (k + 1));
                q   = 4'($urandom);
                case (L)
                    1:       q[1]   = tmp[0];
                    2:       q[1:0] = tmp[1:0];
                    default: q      = tmp[3:0];
                endcase
                dqi_a[i] = q;
            end
            @(negedge clk);
            exp_c = (j <= endj) && ((((j - 1) / D) % 2) == 1);
            chk("sck",  i, 8'(c_a[i]),    8'(exp_c));
            chk("sn",   i, 8'(sn_a[i]),   8'((j > endj) && ds));
            chk("busy", i, 8'(busy_a[i]), 8'h01);
            chk("done", i, 8'(done_a[i]), 8'(j == donej));
            if (j <= endj) begin
                chk("oe", i, 8'(oe_a[i]), exp_oe);
                if (L < 4) chk("hold_wp", i, 8'(dqo_a[i][3:2]), 8'h03);
            end else begin
                chk("oe_end", i, 8'(oe_a[i]),  8'h0D);
                chk("dq_end", i, 8'(dqo_a[i]), 8'h0C);
            end
            if (is_wr && exp_c && (((j - 1) % D) == 0)) begin
                k        = (j - 1) / (2 * D);
                tmp      = d >> (8 - L * (k + 1));
                exp_bits = tmp & mask;
                obs_bits = 8'(dqo_a[i]) & mask;
                chk("wbits", i, obs_bits, exp_bits);
            end
            if (j == donej) chk("dout", i, dout_a[i], is_wr ? dout_m[i] : rb);
            @(posedge clk); #1;
        end
        wr_a[i] = 1'b0;
        rd_a[i] = 1'b0;
        if (!is_wr) dout_m[i] = rb;
        csn_m[i] = ds;
    endtask

    initial begin
        logic [7:0] rb;
        for (int i = 0; i < 3; i++) begin
            wr_a[i] = 1'b0; rd_a[i] = 1'b0; ds_a[i] = 1'b0; md_a[i] = 2'b00;
            din_a[i] = 8'h00; dqi_a[i] = 4'h0;
            dout_m[i] = 8'h00; csn_m[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk_idle_pins("reset", i);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single write A5, D=1: done at T+17, chip select stays low
        do_byte(0, 1'b1, 1'b0, 2'b00, 8'hA5, 1'b0, 8'h00, 1'b0);
        // write and read together -> write; a request poked while busy is ignored
        do_byte(0, 1'b1, 1'b1, 2'b00, 8'h3E, 1'b0, 8'hFF, 1'b1);
        // single read to set dout
        do_byte(0, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 8'h96, 1'b0);
        // mode 11 uses single-lane timing; write leaves dout alone
        do_byte(0, 1'b1, 1'b0, 2'b11, 8'h5A, 1'b0, 8'h00, 1'b0);
        // Quad read with deselect, D=2: 3C, done at T+18
        do_byte(1, 1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 8'h3C, 1'b0);
        // Dual write 1B then back-to-back dual read of AA (dq[1:0]=10 constant)
        do_byte(0, 1'b1, 1'b0, 2'b01, 8'h1B, 1'b0, 8'h00, 1'b0);
        do_byte(0, 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 8'hAA, 1'b0);

        // Randomized bytes across all three dividers
        for (int n = 0; n < 12; n++) begin
            int  i, gap;
            bit  w;
            i   = int'($urandom_range(0, 2));
            w   = 1'($urandom);
            rb  = 8'($urandom);
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge clk); #1; end
            do_byte(i, w, ~w, 2'($urandom), 8'($urandom), 1'($urandom), rb, 1'($urandom));
        end

        // Reset in the middle of a quad read at D=3
        md_a[2] = 2'b10; rd_a[2] = 1'b1; ds_a[2] = 1'b0;
        @(posedge clk); #1;
        rd_a[2] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            dqi_a[2] = 4'($urandom);
            @(posedge clk); #1;
        end
        chk("mid_busy", 2, 8'(busy_a[2]), 8'h01);
        reset_n = 1'b0;
        #1;
        chk_idle_pins("async_rst", 2);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst_done", 2, 8'(done_a[2]), 8'h00);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dout_m[i] = 8'h00;
            csn_m[i]  = 1'b1;
        end
        @(posedge clk); #1;
        rb = 8'($urandom);
        do_byte(2, 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, rb, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
